// File: rtl/axilite_master.sv
// AXI4-Lite initiator: turns a valid/ready command/response pair into single
// AXI4-Lite read or write transactions, one outstanding at a time.
module axilite_master #(
    parameter int unsigned ADDR_SIZE   = 32,
    parameter int unsigned DATA_WIDTH  = 32,
    parameter logic [1:0]  RESP_OKAY   = 2'd0,
    parameter logic [1:0]  RESP_SLVERR = 2'd2,
    parameter logic [1:0]  RESP_DECERR = 2'd3
) (
    input  logic                      aclk,
    input  logic                      aresetn,
    // local command side
    input  logic                      cmd_valid,
    output logic                      cmd_ready,
    input  logic                      cmd_write,
    input  logic [ADDR_SIZE-1:0]      cmd_addr,
    input  logic [DATA_WIDTH-1:0]     cmd_wdata,
    input  logic [DATA_WIDTH/8-1:0]   cmd_wstrb,
    // local response side
    output logic                      rsp_valid,
    input  logic                      rsp_ready,
    output logic                      rsp_write,
    output logic [DATA_WIDTH-1:0]     rsp_rdata,
    output logic [1:0]                rsp_resp,
    output logic                      rsp_err,
    // AXI write channels
    output logic [ADDR_SIZE-1:0]      awaddr,
    output logic                      awvalid,
    input  logic                      awready,
    output logic [DATA_WIDTH-1:0]     wdata,
    output logic [DATA_WIDTH/8-1:0]   wstrb,
    output logic                      wvalid,
    input  logic                      wready,
    input  logic [1:0]                bresp,
    input  logic                      bvalid,
    output logic                      bready,
    // AXI read channels
    output logic [ADDR_SIZE-1:0]      araddr,
    output logic                      arvalid,
    input  logic                      arready,
    input  logic [DATA_WIDTH-1:0]     rdata,
    input  logic [1:0]                rresp,
    input  logic                      rvalid,
    output logic                      rready
);

    localparam int unsigned STRB_W = DATA_WIDTH / 8;

    typedef enum logic [2:0] {
        IDLE         = 3'd0,
        WR_ADDR_DATA = 3'd1,
        WR_RESP      = 3'd2,
        RD_ADDR      = 3'd3,
        RD_DATA      = 3'd4,
        RSP          = 3'd5
    } state_t;

    state_t                  state_q, state_d;

    logic                    cmd_ready_q, cmd_ready_d;
    logic [ADDR_SIZE-1:0]    addr_q, addr_d;
    logic [DATA_WIDTH-1:0]   wdata_q, wdata_d;
    logic [STRB_W-1:0]       wstrb_q, wstrb_d;
    logic                    awvalid_q, awvalid_d;
    logic                    wvalid_q, wvalid_d;
    logic                    bready_q, bready_d;
    logic                    arvalid_q, arvalid_d;
    logic                    rready_q, rready_d;
    logic                    rsp_valid_q, rsp_valid_d;
    logic                    rsp_write_q, rsp_write_d;
    logic [DATA_WIDTH-1:0]   rsp_rdata_q, rsp_rdata_d;
    logic [1:0]              rsp_resp_q, rsp_resp_d;
    logic                    rsp_err_q, rsp_err_d;

    // Error flag is precomputed so it is registered in step with rsp_resp.
    function automatic logic is_err(input logic [1:0] resp);
        return (resp == RESP_SLVERR) || (resp == RESP_DECERR);
    endfunction

    // State register and registered outputs
    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            state_q     <= IDLE;
            cmd_ready_q <= 1'b0;
            addr_q      <= '0;
            wdata_q     <= '0;
            wstrb_q     <= '0;
            awvalid_q   <= 1'b0;
            wvalid_q    <= 1'b0;
            bready_q    <= 1'b0;
            arvalid_q   <= 1'b0;
            rready_q    <= 1'b0;
            rsp_valid_q <= 1'b0;
            rsp_write_q <= 1'b0;
            rsp_rdata_q <= '0;
            rsp_resp_q  <= RESP_OKAY;
            rsp_err_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            cmd_ready_q <= cmd_ready_d;
            addr_q      <= addr_d;
            wdata_q     <= wdata_d;
            wstrb_q     <= wstrb_d;
            awvalid_q   <= awvalid_d;
            wvalid_q    <= wvalid_d;
            bready_q    <= bready_d;
            arvalid_q   <= arvalid_d;
            rready_q    <= rready_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_write_q <= rsp_write_d;
            rsp_rdata_q <= rsp_rdata_d;
            rsp_resp_q  <= rsp_resp_d;
            rsp_err_q   <= rsp_err_d;
        end
    end

    // Next-state and next-output logic; everything holds unless changed below
    always_comb begin
        state_d     = state_q;
        cmd_ready_d = cmd_ready_q;
        addr_d      = addr_q;
        wdata_d     = wdata_q;
        wstrb_d     = wstrb_q;
        awvalid_d   = awvalid_q;
        wvalid_d    = wvalid_q;
        bready_d    = bready_q;
        arvalid_d   = arvalid_q;
        rready_d    = rready_q;
        rsp_valid_d = rsp_valid_q;
        rsp_write_d = rsp_write_q;
        rsp_rdata_d = rsp_rdata_q;
        rsp_resp_d  = rsp_resp_q;
        rsp_err_d   = rsp_err_q;

        unique case (state_q)
            IDLE: begin
                cmd_ready_d = 1'b1;
                if (cmd_valid && cmd_ready_q) begin
                    cmd_ready_d = 1'b0;
                    addr_d      = cmd_addr;
                    wdata_d     = cmd_wdata;
                    wstrb_d     = cmd_wstrb;
                    if (cmd_write) begin
                        awvalid_d = 1'b1;
                        wvalid_d  = 1'b1;
                        state_d   = WR_ADDR_DATA;
                    end else begin
                        arvalid_d = 1'b1;
                        state_d   = RD_ADDR;
                    end
                end
            end

            // AW and W retire independently; move on once both have dropped
            WR_ADDR_DATA: begin
                if (awvalid_q && awready) begin
                    awvalid_d = 1'b0;
                end
                if (wvalid_q && wready) begin
                    wvalid_d = 1'b0;
                end
                if (!awvalid_d && !wvalid_d) begin
                    bready_d = 1'b1;
                    state_d  = WR_RESP;
                end
            end

            WR_RESP: begin
                if (bvalid && bready_q) begin
                    bready_d    = 1'b0;
                    rsp_valid_d = 1'b1;
                    rsp_write_d = 1'b1;
                    rsp_rdata_d = '0;
                    rsp_resp_d  = bresp;
                    rsp_err_d   = is_err(bresp);
                    state_d     = RSP;
                end
            end

            RD_ADDR: begin
                if (arvalid_q && arready) begin
                    arvalid_d = 1'b0;
                    rready_d  = 1'b1;
                    state_d   = RD_DATA;
                end
            end

            RD_DATA: begin
                if (rvalid && rready_q) begin
                    rready_d    = 1'b0;
                    rsp_valid_d = 1'b1;
                    rsp_write_d = 1'b0;
                    rsp_rdata_d = rdata;
                    rsp_resp_d  = rresp;
                    rsp_err_d   = is_err(rresp);
                    state_d     = RSP;
                end
            end

            // Response held until consumed; no command accepted in this cycle
            RSP: begin
                if (rsp_valid_q && rsp_ready) begin
                    rsp_valid_d = 1'b0;
                    cmd_ready_d = 1'b1;
                    state_d     = IDLE;
                end
            end

            default: begin
                state_d = IDLE;
            end
        endcase
    end

    assign cmd_ready = cmd_ready_q;
    assign awaddr    = addr_q;
    assign araddr    = addr_q;
    assign wdata     = wdata_q;
    assign wstrb     = wstrb_q;
    assign awvalid   = awvalid_q;
    assign wvalid    = wvalid_q;
    assign bready    = bready_q;
    assign arvalid   = arvalid_q;
    assign rready    = rready_q;
    assign rsp_valid = rsp_valid_q;
    assign rsp_write = rsp_write_q;
    assign rsp_rdata = rsp_rdata_q;
    assign rsp_resp  = rsp_resp_q;
    assign rsp_err   = rsp_err_q;

endmodule

// File: tb/tb_axilite_master.sv
// Directed bench for axilite_master: AXI slave behaviour is driven by hand
// cycle by cycle and every output is compared against hand-computed values.
module tb_axilite_master;

    localparam int unsigned AW = 32;
    localparam int unsigned DW = 32;
    localparam int unsigned SW = DW / 8;

    logic          aclk;
    logic          aresetn;
    logic          cmd_valid;
    logic          cmd_ready;
    logic          cmd_write;
    logic [AW-1:0] cmd_addr;
    logic [DW-1:0] cmd_wdata;
    logic [SW-1:0] cmd_wstrb;
    logic          rsp_valid;
    logic          rsp_ready;
    logic          rsp_write;
    logic [DW-1:0] rsp_rdata;
    logic [1:0]    rsp_resp;
    logic          rsp_err;
    logic [AW-1:0] awaddr;
    logic          awvalid;
    logic          awready;
    logic [DW-1:0] wdata;
    logic [SW-1:0] wstrb;
    logic          wvalid;
    logic          wready;
    logic [1:0]    bresp;
    logic          bvalid;
    logic          bready;
    logic [AW-1:0] araddr;
    logic          arvalid;
    logic          arready;
    logic [DW-1:0] rdata;
    logic [1:0]    rresp;
    logic          rvalid;
    logic          rready;

    int n_checks = 0;
    int n_fail   = 0;

    axilite_master #(
        .ADDR_SIZE (AW),
        .DATA_WIDTH(DW)
    ) dut (
        .aclk     (aclk),
        .aresetn  (aresetn),
        .cmd_valid(cmd_valid),
        .cmd_ready(cmd_ready),
        .cmd_write(cmd_write),
        .cmd_addr (cmd_addr),
        .cmd_wdata(cmd_wdata),
        .cmd_wstrb(cmd_wstrb),
        .rsp_valid(rsp_valid),
        .rsp_ready(rsp_ready),
        .rsp_write(rsp_write),
        .rsp_rdata(rsp_rdata),
        .rsp_resp (rsp_resp),
        .rsp_err  (rsp_err),
        .awaddr   (awaddr),
        .awvalid  (awvalid),
        .awready  (awready),
        .wdata    (wdata),
        .wstrb    (wstrb),
        .wvalid   (wvalid),
        .wready   (wready),
        .bresp    (bresp),
        .bvalid   (bvalid),
        .bready   (bready),
        .araddr   (araddr),
        .arvalid  (arvalid),
        .arready  (arready),
        .rdata    (rdata),
        .rresp    (rresp),
        .rvalid   (rvalid),
        .rready   (rready)
    );

    initial aclk = 1'b0;
    always #5 aclk = ~aclk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    // One clock cycle; inputs are driven and outputs sampled 1 time unit after the edge
    task automatic tick();
        @(posedge aclk);
        #1;
    endtask

    task automatic issue(input logic wr, input logic [AW-1:0] a,
                         input logic [DW-1:0] d, input logic [SW-1:0] s);
        cmd_valid = 1'b1;
        cmd_write = wr;
        cmd_addr  = a;
        cmd_wdata = d;
        cmd_wstrb = s;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        aresetn   = 1'b0;
        cmd_valid = 1'b0;
        cmd_write = 1'b0;
        cmd_addr  = '0;
        cmd_wdata = '0;
        cmd_wstrb = '0;
        rsp_ready = 1'b0;
        awready   = 1'b0;
        wready    = 1'b0;
        bresp     = 2'd0;
        bvalid    = 1'b0;
        arready   = 1'b0;
        rdata     = '0;
        rresp     = 2'd0;
        rvalid    = 1'b0;

        // ---- reset state ----
        tick();
        tick();
        check("rst_cmd_ready", 64'(cmd_ready), 64'd0);
        check("rst_awvalid",   64'(awvalid),   64'd0);
        check("rst_rsp_valid", 64'(rsp_valid), 64'd0);
        aresetn = 1'b1;
        #1;
        check("rel_cmd_ready_pre", 64'(cmd_ready), 64'd0);
        tick();
        check("rel_cmd_ready", 64'(cmd_ready), 64'd1);

        // ---- write, zero-wait slave ----
        issue(1'b1, 32'h8, 32'hDEADBEEF, 4'hF);              // cycle 0
        tick();                                               // cycle 1
        cmd_valid = 1'b0;
        check("w0_awvalid",  64'(awvalid),   64'd1);
        check("w0_wvalid",   64'(wvalid),    64'd1);
        check("w0_awaddr",   64'(awaddr),    64'h8);
        check("w0_wdata",    64'(wdata),     64'hDEADBEEF);
        check("w0_wstrb",    64'(wstrb),     64'hF);
        check("w0_cmd_ready", 64'(cmd_ready), 64'd0);
        awready = 1'b1;
        wready  = 1'b1;
        tick();                                               // cycle 2
        awready = 1'b0;
        wready  = 1'b0;
        check("w0_bready",   64'(bready),  64'd1);
        check("w0_aw_drop",  64'(awvalid), 64'd0);
        check("w0_w_drop",   64'(wvalid),  64'd0);
        bvalid = 1'b1;
        bresp  = 2'd0;
        tick();                                               // cycle 3
        bvalid = 1'b0;
        check("w0_rsp_valid", 64'(rsp_valid), 64'd1);
        check("w0_rsp_resp",  64'(rsp_resp),  64'd0);
        check("w0_rsp_err",   64'(rsp_err),   64'd0);
        check("w0_rsp_rdata", 64'(rsp_rdata), 64'd0);
        check("w0_rsp_write", 64'(rsp_write), 64'd1);
        check("w0_bready_off", 64'(bready),   64'd0);
        rsp_ready = 1'b1;
        tick();
        rsp_ready = 1'b0;
        check("w0_rsp_done",  64'(rsp_valid), 64'd0);
        check("w0_cmd_ready", 64'(cmd_ready), 64'd1);

        // ---- write, skewed handshakes: W at cycle 1, AW at cycle 4 ----
        issue(1'b1, 32'h8, 32'h11223344, 4'h3);              // cycle 0
        tick();                                               // cycle 1
        cmd_valid = 1'b0;
        wready    = 1'b1;
        tick();                                               // cycle 2
        wready = 1'b0;
        check("w1_c2_wvalid",  64'(wvalid),  64'd0);
        check("w1_c2_awvalid", 64'(awvalid), 64'd1);
        check("w1_c2_bready",  64'(bready),  64'd0);
        tick();                                               // cycle 3
        check("w1_c3_awvalid", 64'(awvalid), 64'd1);
        check("w1_c3_awaddr",  64'(awaddr),  64'h8);
        check("w1_c3_bready",  64'(bready),  64'd0);
        tick();                                               // cycle 4
        check("w1_c4_awvalid", 64'(awvalid), 64'd1);
        check("w1_c4_awaddr",  64'(awaddr),  64'h8);
        awready = 1'b1;
        tick();                                               // cycle 5
        awready = 1'b0;
        check("w1_c5_awvalid", 64'(awvalid), 64'd0);
        check("w1_c5_bready",  64'(bready),  64'd1);
        bvalid = 1'b1;
        bresp  = 2'd3;
        tick();
        bvalid = 1'b0;
        check("w1_rsp_valid", 64'(rsp_valid), 64'd1);
        check("w1_rsp_resp",  64'(rsp_resp),  64'd3);
        check("w1_rsp_err",   64'(rsp_err),   64'd1);
        rsp_ready = 1'b1;
        tick();
        rsp_ready = 1'b0;

        // ---- read with arready delayed 3 cycles and held response ----
        issue(1'b0, 32'hC, 32'h0, 4'h0);                      // cycle 0
        tick();                                               // cycle 1
        cmd_valid = 1'b0;
        check("r0_arvalid", 64'(arvalid), 64'd1);
        check("r0_araddr",  64'(araddr),  64'hC);
        check("r0_awvalid", 64'(awvalid), 64'd0);
        tick();
        tick();
        tick();                                               // cycle 4
        check("r0_arvalid_held", 64'(arvalid), 64'd1);
        check("r0_rready_wait",  64'(rready),  64'd0);
        arready = 1'b1;
        tick();                                               // cycle 5
        arready = 1'b0;
        check("r0_ar_drop", 64'(arvalid), 64'd0);
        check("r0_rready",  64'(rready),  64'd1);
        rvalid = 1'b1;
        rdata  = 32'h12345678;
        rresp  = 2'd2;
        tick();
        rvalid = 1'b0;
        rdata  = 32'hFFFFFFFF;
        rresp  = 2'd0;
        for (int i = 0; i < 4; i++) begin
            check("r0_hold_valid", 64'(rsp_valid), 64'd1);
            check("r0_hold_rdata", 64'(rsp_rdata), 64'h12345678);
            check("r0_hold_resp",  64'(rsp_resp),  64'd2);
            check("r0_hold_err",   64'(rsp_err),   64'd1);
            check("r0_hold_write", 64'(rsp_write), 64'd0);
            check("r0_hold_rready", 64'(rready),   64'd0);
            tick();
        end
        rsp_ready = 1'b1;
        tick();
        rsp_ready = 1'b0;
        check("r0_done", 64'(rsp_valid), 64'd0);

        // ---- back-to-back: read then write, cmd_valid held high ----
        issue(1'b0, 32'h4, 32'h0, 4'h0);                      // cycle 0
        tick();                                               // cycle 1
        issue(1'b1, 32'h10, 32'hCAFEF00D, 4'hC);
        check("bb_arvalid", 64'(arvalid), 64'd1);
        arready = 1'b1;
        tick();                                               // cycle 2
        arready = 1'b0;
        check("bb_rready",  64'(rready),  64'd1);
        check("bb_c2_aw",   64'(awvalid), 64'd0);
        rvalid = 1'b1;
        rdata  = 32'hA5A5A5A5;
        rresp  = 2'd0;
        tick();                                               // cycle 3
        rvalid = 1'b0;
        check("bb_rsp_valid", 64'(rsp_valid), 64'd1);
        check("bb_rsp_rdata", 64'(rsp_rdata), 64'hA5A5A5A5);
        check("bb_c3_ready",  64'(cmd_ready), 64'd0);
        check("bb_c3_aw",     64'(awvalid),   64'd0);
        rsp_ready = 1'b1;
        tick();                                               // rsp handshake edge done
        rsp_ready = 1'b0;
        check("bb_ready_up",  64'(cmd_ready), 64'd1);
        check("bb_no_aw_yet", 64'(awvalid),   64'd0);
        check("bb_no_w_yet",  64'(wvalid),    64'd0);
        check("bb_no_ar",     64'(arvalid),   64'd0);
        tick();                                               // second command accepted
        cmd_valid = 1'b0;
        check("bb_awvalid",  64'(awvalid),   64'd1);
        check("bb_awaddr",   64'(awaddr),    64'h10);
        check("bb_wdata",    64'(wdata),     64'hCAFEF00D);
        check("bb_wstrb",    64'(wstrb),     64'hC);
        check("bb_ready_dn", 64'(cmd_ready), 64'd0);
        awready = 1'b1;
        wready  = 1'b1;
        tick();
        awready = 1'b0;
        wready  = 1'b0;
        bvalid  = 1'b1;
        bresp   = 2'd0;
        tick();
        bvalid = 1'b0;
        check("bb_w_rsp_write", 64'(rsp_write), 64'd1);
        check("bb_w_rsp_rdata", 64'(rsp_rdata), 64'd0);
        check("bb_w_rsp_err",   64'(rsp_err),   64'd0);
        rsp_ready = 1'b1;
        tick();
        rsp_ready = 1'b0;

        // ---- reset mid-write ----
        issue(1'b1, 32'h20, 32'h55AA55AA, 4'hF);
        tick();
        cmd_valid = 1'b0;
        check("rm_awvalid", 64'(awvalid), 64'd1);
        check("rm_wvalid",  64'(wvalid),  64'd1);
        aresetn = 1'b0;
        #1;
        check("rm_aw_clr",   64'(awvalid),   64'd0);
        check("rm_w_clr",    64'(wvalid),    64'd0);
        check("rm_awaddr",   64'(awaddr),    64'd0);
        check("rm_wdata",    64'(wdata),     64'd0);
        check("rm_cmd_rdy",  64'(cmd_ready), 64'd0);
        check("rm_bready",   64'(bready),    64'd0);
        tick();
        aresetn = 1'b1;
        #1;
        check("rm_rel_pre", 64'(cmd_ready), 64'd0);
        tick();
        check("rm_rel_rdy", 64'(cmd_ready), 64'd1);
        issue(1'b0, 32'h30, 32'h0, 4'h0);
        tick();
        cmd_valid = 1'b0;
        check("rm_rd_arvalid", 64'(arvalid), 64'd1);
        check("rm_rd_araddr",  64'(araddr),  64'h30);
        check("rm_rd_awvalid", 64'(awvalid), 64'd0);
        arready = 1'b1;
        tick();
        arready = 1'b0;
        rvalid  = 1'b1;
        rdata   = 32'h0BADF00D;
        rresp   = 2'd1;
        tick();
        rvalid = 1'b0;
        check("rm_rd_valid", 64'(rsp_valid), 64'd1);
        check("rm_rd_rdata", 64'(rsp_rdata), 64'h0BADF00D);
        check("rm_rd_resp",  64'(rsp_resp),  64'd1);
        check("rm_rd_err",   64'(rsp_err),   64'd0);
        rsp_ready = 1'b1;
        tick();
        rsp_ready = 1'b0;

        // ---- stray slave inputs in IDLE ----
        bvalid  = 1'b1;
        rvalid  = 1'b1;
        awready = 1'b1;
        wready  = 1'b1;
        arready = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick();
            check("st_bready",    64'(bready),    64'd0);
            check("st_rready",    64'(rready),    64'd0);
            check("st_rsp_valid", 64'(rsp_valid), 64'd0);
            check("st_cmd_ready", 64'(cmd_ready), 64'd1);
            check("st_awvalid",   64'(awvalid),   64'd0);
            check("st_arvalid",   64'(arvalid),   64'd0);
        end
        bvalid  = 1'b0;
        rvalid  = 1'b0;
        awready = 1'b0;
        wready  = 1'b0;
        arready = 1'b0;
        tick();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/axilite_master.md
Name: axilite_master

Overview:
- AXI4-Lite initiator. Converts a simple valid/ready command/response interface into single AXI4-Lite read or write transactions.
- Used by control-system logic (sequencers, test drivers) to reach AXI-Lite register cells such as the coprocessor's slave register blocks.
- Exactly one transaction is outstanding at a time. The response is held until the local consumer takes it.

Parameters:
- ADDR_SIZE, 32, width of the command address and of awaddr/araddr.
- DATA_WIDTH, 32, AXI data width. Must be a multiple of 8. Strobe width is DATA_WIDTH/8.
- RESP_OKAY, 0, response code passed through unchanged.
- RESP_SLVERR, 2, response code passed through unchanged.
- RESP_DECERR, 3, response code passed through unchanged. rsp_err flags any code other than RESP_OKAY and 1 (EXOKAY).

Ports:
- aclk  in  1  clock; all logic on the rising edge.
- aresetn  in  1  asynchronous active-low reset.
- cmd_valid  in  1  command present.
- cmd_ready  out  1  block can accept a command.
- cmd_write  in  1  1 = write, 0 = read.
- cmd_addr  in  ADDR_SIZE  target byte address.
- cmd_wdata  in  DATA_WIDTH  write data; ignored for reads.
- cmd_wstrb  in  DATA_WIDTH/8  write strobes; ignored for reads.
- rsp_valid  out  1  response present.
- rsp_ready  in  1  consumer takes the response.
- rsp_write  out  1  echo of cmd_write for this response.
- rsp_rdata  out  DATA_WIDTH  read data; 0 for writes.
- rsp_resp  out  2  bresp or rresp as captured.
- rsp_err  out  1  rsp_resp is SLVERR or DECERR.
- awaddr  out  ADDR_SIZE  AXI write address.
- awvalid  out  1  AXI write address valid.
- awready  in  1  AXI write address ready.
- wdata  out  DATA_WIDTH  AXI write data.
- wstrb  out  DATA_WIDTH/8  AXI write strobes.
- wvalid  out  1  AXI write data valid.
- wready  in  1  AXI write data ready.
- bresp  in  2  AXI write response.
- bvalid  in  1  AXI write response valid.
- bready  out  1  AXI write response ready.
- araddr  out  ADDR_SIZE  AXI read address.
- arvalid  out  1  AXI read address valid.
- arready  in  1  AXI read address ready.
- rdata  in  DATA_WIDTH  AXI read data.
- rresp  in  2  AXI read response.
- rvalid  in  1  AXI read data valid.
- rready  out  1  AXI read data ready.

Behaviour:
- Reset (aresetn low) forces, asynchronously:
  - state IDLE;
  - all outputs 0, including cmd_ready, awvalid, wvalid, bready, arvalid, rready, rsp_valid, and the address/data/response registers.
- All outputs are registered; no combinational path from any input to any output.
- First rising edge after reset release sets cmd_ready=1.
- IDLE: cmd_ready=1. On cmd_valid&cmd_ready:
  - latch addr, wdata, wstrb and write flag; cmd_ready goes 0 next cycle.
  - write: awvalid=1 and wvalid=1 next cycle; go to WR_ADDR_DATA.
  - read: arvalid=1 next cycle; go to RD_ADDR.
- WR_ADDR_DATA: AW and W complete independently.
  - awvalid drops the cycle after awvalid&awready; wvalid drops the cycle after wvalid&wready.
  - Handshakes may occur in the same cycle or in either order.
  - awaddr, wdata and wstrb stay stable while their valid is high.
  - Once both handshakes are done, go to WR_RESP with bready=1 the next cycle.
- WR_RESP: on bvalid&bready:
  - capture bresp into rsp_resp; rsp_rdata=0; rsp_write=1; rsp_valid=1; bready=0.
  - go to RSP.
- RD_ADDR: on arvalid&arready, arvalid=0 and rready=1 next cycle; go to RD_DATA.
- RD_DATA: on rvalid&rready:
  - capture rdata and rresp; rsp_write=0; rsp_valid=1; rready=0.
  - go to RSP.
- RSP: rsp_* held stable while rsp_valid=1 and rsp_ready=0.
  - On rsp_valid&rsp_ready: rsp_valid=0 and cmd_ready=1 next cycle; go to IDLE.
  - No same-cycle command acceptance.
- rsp_err = (rsp_resp == RESP_SLVERR) | (rsp_resp == RESP_DECERR). It is registered alongside rsp_resp.
- Minimum latency with a zero-wait slave:
  - command handshake at cycle 0; AXI valids at cycle 1; bready/rready at cycle 2; rsp_valid at cycle 3.
  - Next command accepted 2 cycles after rsp handshake (ready rises 1 cycle after, handshake on that cycle).
- Ready signals are asserted only in their own state:
  - bvalid/rvalid arriving outside WR_RESP/RD_DATA is not acknowledged;
  - stray awready/wready/arready while the matching valid is 0 are ignored.
- Commands presented while cmd_ready=0 are not consumed; cmd_valid may stay high.
- Reset mid-transaction drops all valids immediately and discards the pending response. The system must reset the slave together with this block.

Test Plan:
- Write, zero-wait slave: cmd_write=1, addr 0x8, wdata 0xDEADBEEF, wstrb 0xF.
  - awvalid/wvalid at cycle 1 with awaddr=0x8.
  - bready at cycle 2; bresp=0 gives rsp_valid at cycle 3, rsp_resp=0, rsp_err=0, rsp_rdata=0.
- Write, skewed handshakes: wready at cycle 1, awready at cycle 4.
  - wvalid low from cycle 2; awvalid held with stable 0x8 until cycle 4.
  - bready first high at cycle 5.
- Read with backpressure: addr 0xC, arready delayed 3 cycles, rvalid with rdata 0x12345678 and rresp=2.
  - rsp_rdata=0x12345678, rsp_resp=2, rsp_err=1, rsp_write=0.
  - Response held 4 cycles with rsp_ready=0, unchanged throughout.
- Back-to-back: read then write with cmd_valid held high.
  - Second command accepted exactly 2 cycles after the first rsp handshake.
  - No AXI valid is raised before that acceptance.
- Reset mid-write: aresetn low while awvalid=1 and wvalid=1.
  - All outputs 0 immediately; cmd_ready=1 on the first edge after release.
  - A fresh read then completes normally.
- Stray inputs in IDLE: bvalid=1, rvalid=1, awready=1.
  - No state change; bready=0, rready=0, rsp_valid=0.
